// File: rtl/oled_ssd1331_seq_ctrl_if.sv
// Request/handshake and PMOD pin bundle for the SSD1331 sequencer.
// master: upstream drawing logic; slave: the sequencer itself.
interface oled_ssd1331_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int N_MAX = 16,
  parameter int NW    = $clog2(N_MAX + 1)
);
  logic [1:0]             i_MODE;
  logic                   i_START;
  logic [WIDTH*N_MAX-1:0] i_DATA;
  logic [N_MAX-1:0]       i_DC;
  logic [NW-1:0]          i_N_transmit;
  logic                   o_CS;
  logic                   o_MOSI;
  logic                   o_SCK;
  logic                   o_DC;
  logic                   o_RES;
  logic                   o_VCCEN;
  logic                   o_PMODEN;
  logic                   o_BUSY;
  logic                   o_DONE;
  logic                   o_ON;
  logic                   o_ERR;

  modport master (
    output i_MODE, i_START, i_DATA, i_DC, i_N_transmit,
    input  o_CS, o_MOSI, o_SCK, o_DC, o_RES, o_VCCEN, o_PMODEN,
    input  o_BUSY, o_DONE, o_ON, o_ERR
  );

  modport slave (
    input  i_MODE, i_START, i_DATA, i_DC, i_N_transmit,
    output o_CS, o_MOSI, o_SCK, o_DC, o_RES, o_VCCEN, o_PMODEN,
    output o_BUSY, o_DONE, o_ON, o_ERR
  );
endinterface

// File: rtl/oled_ssd1331_seq_ctrl.sv
// SSD1331 PMOD controller: power-rail/reset sequencing, multi-byte command/data
// bursts with per-byte D/C, and a mode-3 SPI serializer (SCK idles high).
module oled_ssd1331_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int N_MAX   = 16,
  parameter int CLK_DIV = 4,
  parameter int T_PWR   = 20,
  parameter int T_RES   = 10,
  parameter int T_VCC   = 40
) (
  input logic i_CLK,
  input logic i_RST,
  oled_ssd1331_seq_ctrl_if.slave bus
);
  localparam int NW    = $clog2(N_MAX + 1);
  localparam int TM_A  = (T_PWR > T_RES) ? T_PWR : T_RES;
  localparam int TM_B  = (T_VCC > CLK_DIV) ? T_VCC : CLK_DIV;
  localparam int TMAX  = (TM_A > TM_B) ? TM_A : TM_B;
  localparam int CW    = $clog2(TMAX + 1);
  localparam int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0]       MODE_NOP   = 2'b00;
  localparam logic [1:0]       MODE_BURST = 2'b01;
  localparam logic [1:0]       MODE_ON    = 2'b10;
  localparam logic [1:0]       MODE_OFF   = 2'b11;
  localparam logic [WIDTH-1:0] CMD_DISP_ON  = WIDTH'(8'hAF);
  localparam logic [WIDTH-1:0] CMD_DISP_OFF = WIDTH'(8'hAE);
  localparam logic [NW-1:0]    N_MAX_W    = NW'(N_MAX);
  localparam logic [BW-1:0]    LAST_BIT   = BW'(WIDTH - 1);
  localparam logic [CW-1:0]    DIV_LD     = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, PWR_VDD, PWR_RES, PWR_RWAIT, PWR_VCC,
    TX_START, TX_SHIFT, TX_GAP, OFF_VCC, FINISH
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [NW-1:0]          idx;
  logic [NW-1:0]          n_q;
  logic [1:0]             op_q;
  logic [BW-1:0]          bit_cnt;
  logic [WIDTH-1:0]       sh_q;
  logic [WIDTH*N_MAX-1:0] data_q;
  logic [N_MAX-1:0]       dc_q;
  logic                   start_ok;
  logic                   start_bad;
  logic [NW-1:0]          n_clip;
  logic [WIDTH-1:0]       cur_byte;
  logic                   cur_dc;

  // Request qualification: only IDLE listens, and each mode must fit the power state.
  always_comb begin
    start_ok  = 1'b0;
    start_bad = 1'b0;
    n_clip    = (bus.i_N_transmit > N_MAX_W) ? N_MAX_W : bus.i_N_transmit;
    if (state == IDLE && bus.i_START && bus.i_MODE != MODE_NOP) begin
      start_ok  = (bus.i_MODE == MODE_ON) ? !bus.o_ON : bus.o_ON;
      start_bad = !start_ok;
    end
  end

  // Select the byte and D/C flag addressed by the burst index.
  always_comb begin
    cur_byte = '0;
    cur_dc   = 1'b0;
    for (int k = 0; k < N_MAX; k++) begin
      if (idx == NW'(k)) begin
        cur_byte = data_q[k*WIDTH +: WIDTH];
        cur_dc   = dc_q[k];
      end
    end
  end

  // Payload capture on acceptance; power requests carry their one display command.
  always_ff @(posedge i_CLK) begin
    if (start_ok) begin
      if (bus.i_MODE == MODE_BURST) begin
        data_q <= bus.i_DATA;
        dc_q   <= bus.i_DC;
      end else begin
        data_q              <= '0;
        data_q[WIDTH-1:0]   <= (bus.i_MODE == MODE_ON) ? CMD_DISP_ON : CMD_DISP_OFF;
        dc_q                <= '0;
      end
    end
  end

  // Main sequencer: power steps, byte dispatch and bit serialisation, all outputs registered.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      n_q          <= '0;
      op_q         <= MODE_NOP;
      bit_cnt      <= '0;
      sh_q         <= '0;
      bus.o_CS     <= 1'b1;
      bus.o_SCK    <= 1'b1;
      bus.o_MOSI   <= 1'b0;
      bus.o_DC     <= 1'b0;
      bus.o_RES    <= 1'b1;
      bus.o_VCCEN  <= 1'b0;
      bus.o_PMODEN <= 1'b0;
      bus.o_BUSY   <= 1'b0;
      bus.o_DONE   <= 1'b0;
      bus.o_ON     <= 1'b0;
      bus.o_ERR    <= 1'b0;
    end else begin
      bus.o_DONE <= 1'b0;
      bus.o_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          idx <= '0;
          if (start_bad) begin
            bus.o_ERR <= 1'b1;
          end else if (start_ok) begin
            bus.o_BUSY <= 1'b1;
            op_q       <= bus.i_MODE;
            if (bus.i_MODE == MODE_ON) begin
              state        <= PWR_VDD;
              bus.o_PMODEN <= 1'b1;
              cnt          <= CW'(T_PWR - 1);
              n_q          <= NW'(1);
            end else begin
              // TX_GAP with an expired count acts as the byte dispatcher.
              state <= TX_GAP;
              cnt   <= '0;
              n_q   <= (bus.i_MODE == MODE_BURST) ? n_clip : NW'(1);
            end
          end
        end
        PWR_VDD: begin
          if (cnt == '0) begin
            state     <= PWR_RES;
            bus.o_RES <= 1'b0;
            cnt       <= CW'(T_RES - 1);
          end else cnt <= cnt - 1'b1;
        end
        PWR_RES: begin
          if (cnt == '0) begin
            state     <= PWR_RWAIT;
            bus.o_RES <= 1'b1;
            cnt       <= CW'(T_PWR - 1);
          end else cnt <= cnt - 1'b1;
        end
        PWR_RWAIT: begin
          if (cnt == '0) begin
            state       <= PWR_VCC;
            bus.o_VCCEN <= 1'b1;
            cnt         <= CW'(T_VCC - 1);
          end else cnt <= cnt - 1'b1;
        end
        PWR_VCC: begin
          if (cnt == '0) begin
            state <= TX_GAP;
            cnt   <= '0;
          end else cnt <= cnt - 1'b1;
        end
        TX_START: begin
          if (cnt == '0) begin
            state     <= TX_SHIFT;
            bus.o_SCK <= 1'b0;
            bit_cnt   <= '0;
            cnt       <= DIV_LD;
          end else cnt <= cnt - 1'b1;
        end
        TX_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt <= DIV_LD;
            if (!bus.o_SCK) begin
              bus.o_SCK <= 1'b1;
            end else if (bit_cnt == LAST_BIT) begin
              state    <= TX_GAP;
              bus.o_CS <= 1'b1;
              idx      <= idx + 1'b1;
            end else begin
              // MOSI only moves on the falling edge so it is stable at the panel's rising-edge sample.
              bus.o_SCK  <= 1'b0;
              bit_cnt    <= bit_cnt + 1'b1;
              sh_q       <= sh_q << 1;
              bus.o_MOSI <= sh_q[WIDTH-2];
            end
          end
        end
        TX_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (idx < n_q) begin
            state      <= TX_START;
            bus.o_CS   <= 1'b0;
            bus.o_DC   <= cur_dc;
            bus.o_MOSI <= cur_byte[WIDTH-1];
            sh_q       <= cur_byte;
            cnt        <= DIV_LD;
          end else if (op_q == MODE_OFF) begin
            state       <= OFF_VCC;
            bus.o_VCCEN <= 1'b0;
            cnt         <= CW'(T_VCC - 1);
          end else begin
            state      <= FINISH;
            bus.o_BUSY <= 1'b0;
            bus.o_DONE <= 1'b1;
            if (op_q == MODE_ON) bus.o_ON <= 1'b1;
          end
        end
        OFF_VCC: begin
          if (cnt == '0) begin
            state        <= FINISH;
            bus.o_PMODEN <= 1'b0;
            bus.o_ON     <= 1'b0;
            bus.o_BUSY   <= 1'b0;
            bus.o_DONE   <= 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/oled_ssd1331_seq_ctrl.md
Name: oled_ssd1331_seq_ctrl

Overview:
- Parametrised successor to the single-byte SSD1331 PMOD interface.
- Combines three functions: the power-rail and reset sequencer (PMODEN, RES, VCCEN), a multi-byte command/data burst engine with per-byte D/C, and an internal SPI mode-3 serializer with a programmable SCK divider.
- Sits between the display-drawing logic and the PMOD pins; the upstream logic issues power-on, burst and power-off requests through a mode/start handshake.

Parameters:
- WIDTH, 8: bits per SPI byte, shifted MSB first.
- N_MAX, 16: maximum bytes per burst.
- CLK_DIV, 4: SCK half-period in i_CLK cycles; must be ≥ 1.
- T_PWR, 20: i_CLK cycles to wait after PMODEN rises, and again after RES releases.
- T_RES, 10: i_CLK cycles RES is held low.
- T_VCC, 40: i_CLK cycles to wait after VCCEN rises, or after it falls on power-off.
- Derived: NW = $clog2(N_MAX+1).

Ports:
- i_CLK  in  1  system clock.
- i_RST  in  1  asynchronous, active-high reset.
- i_MODE  in  2  request type: 00 nop, 01 burst, 10 power-on, 11 power-off.
- i_START  in  1  request strobe; sampled only while o_BUSY=0.
- i_DATA  in  WIDTH*N_MAX  burst bytes; byte k is i_DATA[k*WIDTH +: WIDTH].
- i_DC  in  N_MAX  D/C per byte; i_DC[k] applies to byte k (0=command, 1=data).
- i_N_transmit  in  NW  burst length.
- o_CS  out  1  SPI chip select, active low.
- o_MOSI  out  1  SPI data.
- o_SCK  out  1  SPI clock, idles high.
- o_DC  out  1  data/command select to the panel.
- o_RES  out  1  panel reset, active low.
- o_VCCEN  out  1  VCC enable, active high.
- o_PMODEN  out  1  VDD logic rail enable, active high.
- o_BUSY  out  1  request in progress.
- o_DONE  out  1  one-cycle pulse when a request completes.
- o_ON  out  1  panel powered and display on.
- o_ERR  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset: asynchronous, active-high, and it overrides everything including an operation in progress.
  - Reset values: o_CS=1, o_SCK=1, o_MOSI=0, o_DC=0, o_RES=1, o_VCCEN=0, o_PMODEN=0, o_BUSY=0, o_DONE=0, o_ON=0, o_ERR=0.
  - State returns to IDLE and all counters clear.
- Handshake: in IDLE, i_START=1 with i_MODE≠00 is accepted; o_BUSY=1 from the next cycle.
  - i_DATA, i_DC and i_N_transmit are latched on acceptance; later input changes are ignored.
  - i_START is ignored while o_BUSY=1.
  - i_START with i_MODE=00 does nothing.
- Rejection: o_ERR pulses one cycle after i_START, o_BUSY stays 0 and no pins change, when:
  - a burst is requested with o_ON=0;
  - power-on is requested with o_ON=1;
  - power-off is requested with o_ON=0.
- States: IDLE, PWR_VDD, PWR_RES, PWR_RWAIT, PWR_VCC, TX_START, TX_SHIFT, TX_GAP, OFF_VCC, FINISH.
- Power-on sequence:
  - PWR_VDD: o_PMODEN=1, wait T_PWR.
  - PWR_RES: o_RES=0 for T_RES.
  - PWR_RWAIT: o_RES=1, wait T_PWR.
  - PWR_VCC: o_VCCEN=1, wait T_VCC.
  - Then send the single internal byte 0xAF with DC=0 (display on) through TX_*.
  - Then FINISH: o_ON=1, o_DONE pulse.
- Power-off sequence:
  - Send 0xAE with DC=0 (display off).
  - OFF_VCC: o_VCCEN=0, wait T_VCC.
  - Then o_PMODEN=0, o_ON=0, o_DONE pulse.
- Burst:
  - Bytes go out in index order 0..n-1, where n = min(i_N_transmit, N_MAX).
  - n=0: no pin activity; o_DONE one cycle after o_BUSY rises.
- Per byte, starting in TX_START:
  - o_CS=0 and o_DC set to that byte's D/C, held stable until CS rises.
  - o_MOSI presents the MSB; wait CLK_DIV cycles.
  - TX_SHIFT: o_SCK goes low for CLK_DIV cycles, then high for CLK_DIV cycles; 8 such periods.
  - MOSI changes only on the SCK falling edge; the panel samples on the rising edge.
  - After the 8th rising edge, TX_GAP: o_CS=1 for CLK_DIV cycles, then the next byte or FINISH.
  - Byte duration: (2*WIDTH+2)*CLK_DIV cycles including the gap.
- FINISH: o_DONE=1 for one cycle, o_BUSY=0 in the same cycle; a new i_START is accepted from the following cycle.
- Reset mid-burst: CS deasserts immediately and the partial byte is discarded.
- Reset during power-on: rails drop immediately (VCCEN and PMODEN go to 0).

Test Plan:
- Reset, then power-on with CLK_DIV=2: PMODEN rises 1 cycle after START; RES is low for exactly 10 cycles, starting 20 cycles later; VCCEN rises 20 cycles after RES release; one byte 0xAF is sent with DC=0; o_ON=1 and o_DONE pulses once.
- Burst with n=3, bytes {0x15,0x00,0x5F}, i_DC=3'b000, CLK_DIV=2: three CS-low windows of 34 cycles, each followed by a 2-cycle CS gap; MOSI bits sampled on rising SCK match MSB-first; SCK toggles every 2 cycles; o_DONE pulses after the 3rd gap.
- Mixed D/C burst n=2, i_DC=2'b10, bytes {0xAA,0x55}: o_DC=0 throughout byte 0 and o_DC=1 throughout byte 1; i_DATA changed mid-burst does not affect the output.
- Error and edge cases:
  - Burst while o_ON=0 → o_ERR pulse, no CS activity.
  - Burst with n=0 while on → o_DONE pulse with no SCK edges.
  - i_N_transmit=20 with N_MAX=16 → exactly 16 bytes sent.
  - i_START during o_BUSY → ignored.
- Asynchronous i_RST asserted mid-byte of a burst → same cycle: CS=1, SCK=1, VCCEN=0, PMODEN=0, o_ON=0; after release a power-on runs normally.
- Power-off from the on state → 0xAE sent with DC=0, VCCEN falls, PMODEN falls 40 cycles later, o_ON=0, o_DONE pulses.
